// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared types and constants for the MIPS write-back slice
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One pending register-file write
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // Buffer occupancy classification
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  // Write-back data select: load data or ALU result
  function automatic logic [DATA_W-1:0] wb_mux(
    input logic              memtoreg,
    input logic [DATA_W-1:0] alu_res,
    input logic [DATA_W-1:0] mem_dat
  );
    return memtoreg ? mem_dat : alu_res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module   : wb_fifo
// Brief    : DEPTH-entry synchronous FIFO of wb_entry_t with age-ordered
//            read-out of every slot (slot 0 = oldest) for forwarding lookup
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  wb_entry_t             i_din,
  input  logic                  i_pop,
  output wb_entry_t             o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output wb_entry_t [DEPTH-1:0] o_age_entry,
  output logic      [DEPTH-1:0] o_age_vld
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  occ_state_t       r_state;

  logic             w_do_push;
  logic             w_do_pop;
  logic [CW-1:0]    w_count_nxt;

  // Push/pop are self-protected so an overflow or underflow can never corrupt pointers
  assign w_do_push   = i_push & (r_state != OCC_FULL);
  assign w_do_pop    = i_pop  & (r_state != OCC_EMPTY);
  assign w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);

  assign o_full  = (r_state == OCC_FULL);
  assign o_empty = (r_state == OCC_EMPTY);
  assign o_dout  = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy state; pointers wrap naturally (DEPTH is a power of 2)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= OCC_EMPTY;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      if (w_count_nxt == '0)
        r_state <= OCC_EMPTY;
      else if (w_count_nxt == CW'(DEPTH))
        r_state <= OCC_FULL;
      else
        r_state <= OCC_PARTIAL;
    end
  end

  // Present slots oldest-first so the consumer can pick the youngest match by scan order
  always_comb begin
    o_age_entry = '0;
    o_age_vld   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      o_age_entry[k] = r_mem[AW'(r_rd_ptr + AW'(k))];
      o_age_vld[k]   = (CW'(k) < r_count);
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_writeback.sv
// ============================================================================
// Module   : regfile_writeback
// Brief    : MIPS write-back stage. Buffers MEM-stage results and issues one
//            register-file write per cycle; optional forwarding of pending
//            results to decode (enable with macro WB_FWD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]     in_alu_res,
  input  logic [DATA_W-1:0]     in_mem_dat,
  input  logic                  in_memtoreg,
  input  logic                  in_regwrite,
  input  logic                  wb_hold,
  output logic [REG_ADDR_W-1:0] write_add,
  output logic [DATA_W-1:0]     write_dat,
  output logic                  regwrite,
  input  logic [REG_ADDR_W-1:0] fwd_reg_1,
  input  logic [REG_ADDR_W-1:0] fwd_reg_2,
  output logic                  fwd_hit_1,
  output logic                  fwd_hit_2,
  output logic [DATA_W-1:0]     fwd_dat_1,
  output logic [DATA_W-1:0]     fwd_dat_2,
  output logic [CNT_W-1:0]      wb_count
);

  wb_entry_t             w_in_entry;
  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_age_entry;
  logic      [DEPTH-1:0] w_age_vld;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  // Ready depends only on registered occupancy: a same-cycle drain does not free a slot early
  assign in_ready = ~w_full;

  // Non-writing instructions and $zero targets are filtered out before buffering
  assign w_push          = in_valid & in_ready & in_regwrite & (in_dest != REG_ZERO);
  assign w_pop           = ~w_empty & ~wb_hold;
  assign w_in_entry.addr = in_dest;
  assign w_in_entry.data = wb_mux(in_memtoreg, in_alu_res, in_mem_dat);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_din       (w_in_entry),
    .i_pop       (w_pop),
    .o_dout      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_age_entry (w_age_entry),
    .o_age_vld   (w_age_vld)
  );

  // Register-file write port: one-cycle regwrite pulse per pop, address/data hold last write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_add <= '0;
      write_dat <= '0;
      regwrite  <= 1'b0;
      wb_count  <= '0;
    end else begin
      regwrite <= w_pop;
      if (w_pop) begin
        write_add <= w_head.addr;
        write_dat <= w_head.data;
        wb_count  <= wb_count + 1'b1;
      end
    end
  end

`ifdef WB_FWD_EN
  // Forwarding: the write in flight is oldest, then buffer slots oldest-first; later matches override
  always_comb begin
    fwd_hit_1 = 1'b0;
    fwd_dat_1 = '0;
    fwd_hit_2 = 1'b0;
    fwd_dat_2 = '0;
    if (regwrite && (write_add == fwd_reg_1)) begin
      fwd_hit_1 = 1'b1;
      fwd_dat_1 = write_dat;
    end
    if (regwrite && (write_add == fwd_reg_2)) begin
      fwd_hit_2 = 1'b1;
      fwd_dat_2 = write_dat;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (w_age_vld[k] && (w_age_entry[k].addr == fwd_reg_1)) begin
        fwd_hit_1 = 1'b1;
        fwd_dat_1 = w_age_entry[k].data;
      end
      if (w_age_vld[k] && (w_age_entry[k].addr == fwd_reg_2)) begin
        fwd_hit_2 = 1'b1;
        fwd_dat_2 = w_age_entry[k].data;
      end
    end
    // $zero is never buffered, but a query for it must never hit regardless
    if (fwd_reg_1 == REG_ZERO) begin
      fwd_hit_1 = 1'b0;
      fwd_dat_1 = '0;
    end
    if (fwd_reg_2 == REG_ZERO) begin
      fwd_hit_2 = 1'b0;
      fwd_dat_2 = '0;
    end
  end
`else
  // Forwarding disabled: ports tied off, read-out and query inputs intentionally unused
  logic w_unused_fwd;
  assign w_unused_fwd = ^{w_age_entry, w_age_vld, fwd_reg_1, fwd_reg_2};
  assign fwd_hit_1    = 1'b0;
  assign fwd_hit_2    = 1'b0;
  assign fwd_dat_1    = '0;
  assign fwd_dat_2    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
// Module   : tb_regfile_writeback
// Brief    : Scoreboard bench for regfile_writeback (DEPTH=2, CNT_W=16)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback;
  import mips_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_dest = '0;
  logic [DATA_W-1:0]     in_alu_res = '0;
  logic [DATA_W-1:0]     in_mem_dat = '0;
  logic                  in_memtoreg = 1'b0;
  logic                  in_regwrite = 1'b0;
  logic                  wb_hold = 1'b0;
  logic [REG_ADDR_W-1:0] write_add;
  logic [DATA_W-1:0]     write_dat;
  logic                  regwrite;
  logic [REG_ADDR_W-1:0] fwd_reg_1 = '0;
  logic [REG_ADDR_W-1:0] fwd_reg_2 = '0;
  logic                  fwd_hit_1, fwd_hit_2;
  logic [DATA_W-1:0]     fwd_dat_1, fwd_dat_2;
  logic [CNT_W-1:0]      wb_count;

  regfile_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_alu_res(in_alu_res), .in_mem_dat(in_mem_dat),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .wb_hold(wb_hold),
    .write_add(write_add), .write_dat(write_dat), .regwrite(regwrite),
    .fwd_reg_1(fwd_reg_1), .fwd_reg_2(fwd_reg_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_dat_1(fwd_dat_1), .fwd_dat_2(fwd_dat_2), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int        vectors = 0;
  int        miscompares = 0;
  int        cyc = 0;
  int        n_wr = 0;
  int        exp_count = 0;
  wb_entry_t sb[$];
  int        pulse_cyc[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && regwrite) begin
      wb_entry_t e;
      n_wr++;
      pulse_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(write_add), 64'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("write_add", 64'(write_add), 64'(e.addr));
        chk("write_dat", 64'(write_dat), 64'(e.data));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one MEM-stage result; called at posedge+1, returns at posedge+1 after acceptance
  task automatic send(input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] mem,
                      input logic m2r, input logic rw);
    bit acc = 0;
    in_valid    = 1'b1;
    in_dest     = dest;
    in_alu_res  = alu;
    in_mem_dat  = mem;
    in_memtoreg = m2r;
    in_regwrite = rw;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        if (rw && dest != 5'd0) begin
          sb.push_back('{addr: dest, data: (m2r ? mem : alu)});
          exp_count++;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    // Reset state
    @(negedge clk);
    chk("rst_regwrite", 64'(regwrite), 64'd0);
    chk("rst_write_add", 64'(write_add), 64'd0);
    chk("rst_write_dat", 64'(write_dat), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_count", 64'(wb_count), 64'd0);
    chk("rst_fwd_hit", 64'({fwd_hit_1, fwd_hit_2}), 64'd0);
    chk("rst_fwd_dat", 64'({fwd_dat_1, fwd_dat_2}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cycles(2);

    // Single write with latency check
    send(5'd1, 32'h0000_000F, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_regwrite_early", 64'(regwrite), 64'd0);
    @(negedge clk);
    chk("lat_regwrite", 64'(regwrite), 64'd1);
    chk("lat_write_add", 64'(write_add), 64'd1);
    chk("lat_write_dat", 64'(write_dat), 64'h0F);
    @(negedge clk);
    chk("pulse_one_cycle", 64'(regwrite), 64'd0);
    chk("hold_write_add", 64'(write_add), 64'd1);
    chk("count_single", 64'(wb_count), 64'(exp_count));
    @(posedge clk); #1;

    // Load path
    send(5'd2, 32'h0000_DEAD, 32'h0000_00F0, 1'b1, 1'b1);
    wait_cycles(4);
    chk("load_write_dat", 64'(write_dat), 64'hF0);

    // $zero and non-writing drops
    snap = n_wr;
    send(5'd0, 32'h1234, 32'h0, 1'b0, 1'b1);
    send(5'd3, 32'h5678, 32'h0, 1'b0, 1'b0);
    wait_cycles(5);
    chk("drop_no_write", 64'(n_wr), 64'(snap));
    chk("drop_count", 64'(wb_count), 64'(exp_count));

    // Backpressure: fill under hold, release, expect 4,5,6 on consecutive cycles
    wb_hold = 1'b1;
    send(5'd4, 32'h44, 32'h0, 1'b0, 1'b1);
    send(5'd5, 32'h55, 32'h0, 1'b0, 1'b1);
    wait_cycles(3);
    @(negedge clk);
    chk("bp_in_ready_full", 64'(in_ready), 64'd0);
    chk("bp_no_write", 64'(regwrite), 64'd0);
    @(posedge clk); #1;
    pulse_cyc.delete();
    wb_hold = 1'b0;
    send(5'd6, 32'h66, 32'h0, 1'b0, 1'b1);
    wait_cycles(5);
    chk("bp_pulses", 64'(pulse_cyc.size()), 64'd3);
    if (pulse_cyc.size() == 3) begin
      chk("bp_consec_a", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd1);
      chk("bp_consec_b", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'd1);
    end
    chk("bp_count", 64'(wb_count), 64'(exp_count));

    // Forwarding lookup on pending entries
    wb_hold = 1'b1;
    send(5'd5, 32'h11, 32'h0, 1'b0, 1'b1);
    send(5'd5, 32'h22, 32'h0, 1'b0, 1'b1);
    fwd_reg_1 = 5'd5;
    fwd_reg_2 = 5'd0;
    #1;
`ifdef WB_FWD_EN
    chk("fwd_hit_1", 64'(fwd_hit_1), 64'd1);
    chk("fwd_dat_1", 64'(fwd_dat_1), 64'h22);
`else
    chk("fwd_hit_1", 64'(fwd_hit_1), 64'd0);
    chk("fwd_dat_1", 64'(fwd_dat_1), 64'd0);
`endif
    chk("fwd_hit_2_zero", 64'(fwd_hit_2), 64'd0);
    fwd_reg_2 = 5'd7;
    #1;
    chk("fwd_hit_2_miss", 64'(fwd_hit_2), 64'd0);
    fwd_reg_1 = 5'd0;
    fwd_reg_2 = 5'd0;
    wb_hold = 1'b0;
    wait_cycles(5);
    chk("fwd_count", 64'(wb_count), 64'(exp_count));

    // Reset mid-operation
    wb_hold = 1'b1;
    send(5'd8, 32'h88, 32'h0, 1'b0, 1'b1);
    send(5'd9, 32'h99, 32'h0, 1'b0, 1'b1);
    wb_hold = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_regwrite", 64'(regwrite), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    exp_count = 0;
    #1;
    chk("rst_async_regwrite", 64'(regwrite), 64'd0);
    chk("rst_async_write_add", 64'(write_add), 64'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    snap = n_wr;
    wait_cycles(6);
    chk("post_rst_no_write", 64'(n_wr), 64'(snap));
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_count", 64'(wb_count), 64'd0);

    // Scoreboard must be drained
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
